// File: rtl/spi_master_seq.sv
// SPI master sequencer: one command byte plus 0..MAXB data bytes per frame, programmable sclk divider and mode.
// Define SPI_MASTER_ABORT_EN to add the 'abort' input, which terminates a frame early.
module spi_master_seq #(
  parameter int MAXB = 8
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start,
  input  logic [7:0]        cmd,
  input  logic [3:0]        nbytes,
  input  logic [8*MAXB-1:0] wdata,
  input  logic [7:0]        clkdiv,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsbfirst,
`ifdef SPI_MASTER_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic              done,
  output logic [8*MAXB-1:0] rdata,
  output logic              sclk,
  output logic              mosi,
  output logic              ss,
  input  logic              miso
);

  localparam int FW = 8 * (MAXB + 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t          state, state_nxt;
  logic [7:0]      div_cnt, clkdiv_q;
  logic [3:0]      nb_q, nb_clamp;
  logic [FW-1:0]   frame_q;
  logic            cpol_q, cpha_q, lsb_q;
  logic [6:0]      bit_cnt;
  logic            ph;
  logic [7:0]      rx_byte, rx_nxt;
  logic            div_done, last_edge, accept, tick, finish, kill;
  logic [6:0]      tx_idx, tx_flat;
  logic [2:0]      tx_pos, rx_pos;
  logic            tx_val, first_bit;

  // ph=0: next edge is leading (away from cpol); ph=1: next edge is trailing.
  always_comb begin
    div_done  = (div_cnt == clkdiv_q);
    last_edge = ph && (bit_cnt == {nb_q, 3'b111});
    tx_idx    = ph ? bit_cnt + 7'd1 : bit_cnt;
    tx_pos    = lsb_q ? tx_idx[2:0] : ~tx_idx[2:0];
    tx_flat   = {tx_idx[6:3], tx_pos};
    tx_val    = (int'(tx_flat) < FW) ? frame_q[tx_flat] : 1'b0;
    rx_pos    = lsb_q ? bit_cnt[2:0] : ~bit_cnt[2:0];
    rx_nxt    = rx_byte;
    rx_nxt[rx_pos] = miso;
    nb_clamp  = (nbytes > 4'(MAXB)) ? 4'(MAXB) : nbytes;
    first_bit = lsbfirst ? cmd[0] : cmd[7];
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    tick      = 1'b0;
    finish    = 1'b0;
    kill      = 1'b0;
    case (state)
      IDLE:  if (start) begin
               accept    = 1'b1;
               state_nxt = SETUP;
             end
      SETUP: if (div_done) state_nxt = SHIFT;
      SHIFT: if (div_done) begin
               tick = 1'b1;
               if (last_edge) state_nxt = HOLD;
             end
      HOLD:  if (div_done) begin
               finish    = 1'b1;
               state_nxt = IDLE;
             end
      default: state_nxt = IDLE;
    endcase
`ifdef SPI_MASTER_ABORT_EN
    if (abort && state != IDLE) begin
      kill      = 1'b1;
      tick      = 1'b0;
      finish    = 1'b0;
      state_nxt = IDLE;
    end
`endif
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ss       <= 1'b1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rdata    <= '0;
      div_cnt  <= '0;
      clkdiv_q <= '0;
      nb_q     <= '0;
      frame_q  <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      bit_cnt  <= '0;
      ph       <= 1'b0;
      rx_byte  <= '0;
    end else begin
      done <= finish | kill;
      if (accept || div_done || state == IDLE) div_cnt <= '0;
      else                                     div_cnt <= div_cnt + 8'd1;

      if (accept) begin
        frame_q  <= {wdata, cmd};
        nb_q     <= nb_clamp;
        clkdiv_q <= clkdiv;
        cpol_q   <= cpol;
        cpha_q   <= cpha;
        lsb_q    <= lsbfirst;
        ss       <= 1'b0;
        busy     <= 1'b1;
        sclk     <= cpol;
        mosi     <= first_bit;
        bit_cnt  <= '0;
        ph       <= 1'b0;
      end else if (finish || kill) begin
        ss   <= 1'b1;
        busy <= 1'b0;
        sclk <= cpol_q;
      end else if (state == IDLE) begin
        sclk <= cpol;
      end else if (tick) begin
        sclk <= ~sclk;
        ph   <= ~ph;
        if (ph) bit_cnt <= bit_cnt + 7'd1;
        // Launch on the edge opposite the sampling edge; cpha=0 has no launch after the final bit.
        if ((cpha_q != ph) && !last_edge) mosi <= tx_val;
        if (ph == cpha_q) begin
          rx_byte <= rx_nxt;
          // Only whole data bytes reach rdata, so an aborted partial byte is dropped.
          if (bit_cnt[2:0] == 3'd7)
            for (int i = 0; i < MAXB; i++)
              if (bit_cnt[6:3] == 4'(i + 1)) rdata[8*i +: 8] <= rx_nxt;
        end
      end
    end
  end

endmodule
